apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter PDATA_SIZE, default 32, APB data width (multiple of 8).
REQ-002 SHALL have parameter PADDR_SIZE, default 4, APB address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase cycles before abort (timeout build only).
REQ-004 SHALL have port APB_CLK  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port APB_RESET_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  host request present.
REQ-007 SHALL have port req_ready  out  1  bridge accepts request this cycle.
REQ-008 SHALL have port req_write  in  1  1=write, 0=read.
REQ-009 SHALL have port req_addr  in  PADDR_SIZE  register address.
REQ-010 SHALL have port req_wdata  in  PDATA_SIZE  write data.
REQ-011 SHALL have port req_strb  in  PDATA_SIZE/8  byte strobes.
REQ-012 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  out  PDATA_SIZE  read data; zero for writes.
REQ-014 SHALL have port rsp_err  out  1  slave error or timeout.
REQ-015 SHALL have ports APB_PSEL, APB_PENABLE, APB_PWRITE  out  1 each; APB_PADDR  out  PADDR_SIZE; APB_PSTRB  out  PDATA_SIZE/8; APB_PWDATA  out  PDATA_SIZE.
REQ-016 SHALL have ports APB_PRDATA  in  PDATA_SIZE; APB_PREADY  in  1; APB_PSLEVRR  in  1 (slave error).

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, ACCESS; all outputs registered.
REQ-018 SHALL drive req_ready=1 only in IDLE; handshake = req_valid & req_ready latches write/addr/wdata/strb and moves to SETUP.
REQ-019 SHALL in SETUP drive PSEL=1, PENABLE=0, latched PADDR/PWRITE/PSTRB/PWDATA for exactly one cycle, then go to ACCESS.
REQ-020 SHALL in ACCESS hold PSEL=1, PENABLE=1 and all address/data/control stable until APB_PREADY=1 (unbounded wait states without timeout build).
REQ-021 SHALL on the ACCESS cycle with APB_PREADY=1 capture APB_PRDATA (reads only) and APB_PSLEVRR, go to IDLE, deassert PSEL/PENABLE, and pulse rsp_valid the next cycle.
REQ-022 SHALL drive PSTRB to all zeros for reads regardless of req_strb.
REQ-023 SHALL hold rsp_rdata/rsp_err stable until next rsp_valid.
REQ-024 SHALL ignore APB_PREADY/APB_PSLEVRR outside ACCESS.
REQ-025 SHALL take 3 cycles minimum per zero-wait transfer (accept, SETUP, ACCESS); back-to-back requests accepted in the IDLE cycle coinciding with rsp_valid.
REQ-026 SHALL ignore req_valid deasserting after acceptance; transfer completes.

Reset
REQ-027 SHALL on APB_RESET_n=0 immediately force IDLE, req_ready=0 during reset and 1 on first cycle after, all APB outputs 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter 0.
REQ-028 SHALL abandon an in-flight transfer on reset with no rsp_valid issued.

Configuration
REQ-029 SHALL compile the ACCESS-phase timeout only when macro APB_BRIDGE_TIMEOUT_EN is defined.
REQ-030 SHALL with APB_BRIDGE_TIMEOUT_EN: count ACCESS cycles from 1; if APB_PREADY still 0 on count TIMEOUT_CYCLES, abort to IDLE, rsp_valid pulse with rsp_err=1, rsp_rdata=0; counter cleared on entering ACCESS.
REQ-031 SHALL without the macro: no counter logic; TIMEOUT_CYCLES unused.

Structure
REQ-032 SHALL place FSM state enum and GPIO register address constants (MODE=0, DIRECTION=1, OUTPUT=2, INPUT=3) in shared package apb_pkg.
REQ-033 SHALL be a single module; no sub-modules.

Verification
REQ-034 Write addr 1, wdata 0x0000_00FF, strb 4'b1111, PREADY tied 1 -> SETUP then ACCESS one cycle each, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-035 Read addr 3, PREADY low 4 ACCESS cycles, PRDATA=0xA5A5_5A5A -> PSEL/PENABLE/PADDR stable 5 ACCESS cycles, rsp_rdata=0xA5A5_5A5A.
REQ-036 Write with PSLEVRR=1 at PREADY -> rsp_err=1; following read with PSLEVRR=0 -> rsp_err=0.
REQ-037 Two back-to-back requests with req_valid held high -> second accepted in rsp_valid cycle, period 3 cycles, no PSEL gap other than IDLE cycle.
REQ-038 APB_RESET_n pulsed low during ACCESS -> outputs zero asynchronously, no rsp_valid; next request completes normally.
REQ-039 With APB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB master bridge.
// Holds the bridge FSM state encoding and the GPIO register map
// used by software and test sequences that talk through the bridge.
package apb_pkg;

    // Bridge FSM states: idle/accepting, APB setup phase, APB access phase
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // GPIO peripheral register addresses
    localparam int unsigned ADDR_MODE      = 0;
    localparam int unsigned ADDR_DIRECTION = 1;
    localparam int unsigned ADDR_OUTPUT    = 2;
    localparam int unsigned ADDR_INPUT     = 3;

endpackage

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns single host requests (valid/ready) into APB
// SETUP/ACCESS transfers and returns a one-cycle response pulse.
// Build macro APB_BRIDGE_TIMEOUT_EN adds an ACCESS-phase timeout that
// aborts a transfer after TIMEOUT_CYCLES cycles without APB_PREADY.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int PDATA_SIZE     = 32,
    parameter int PADDR_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    APB_CLK,
    input  logic                    APB_RESET_n,
    // host request side
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [PADDR_SIZE-1:0]   req_addr,
    input  logic [PDATA_SIZE-1:0]   req_wdata,
    input  logic [PDATA_SIZE/8-1:0] req_strb,
    // host response side
    output logic                    rsp_valid,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // APB master side
    output logic                    APB_PSEL,
    output logic                    APB_PENABLE,
    output logic                    APB_PWRITE,
    output logic [PADDR_SIZE-1:0]   APB_PADDR,
    output logic [PDATA_SIZE/8-1:0] APB_PSTRB,
    output logic [PDATA_SIZE-1:0]   APB_PWDATA,
    input  logic [PDATA_SIZE-1:0]   APB_PRDATA,
    input  logic                    APB_PREADY,
    input  logic                    APB_PSLEVRR
);

    // Reject configurations the byte strobes and timeout cannot represent
    if ((PDATA_SIZE % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master_bridge: PDATA_SIZE must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    apb_state_t state;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Holds (ACCESS cycle number - 1) of the current access phase
    logic [CNT_W-1:0] access_cnt;
`endif

    // Bridge FSM: every output is a register updated alongside the state
    always_ff @(posedge APB_CLK or negedge APB_RESET_n) begin
        if (!APB_RESET_n) begin
            // NOTE: the data/address registers are reset too, because they
            // drive ports that must read zero while reset is asserted.
            state       <= IDLE;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            APB_PSEL    <= 1'b0;
            APB_PENABLE <= 1'b0;
            APB_PWRITE  <= 1'b0;
            APB_PADDR   <= '0;
            APB_PSTRB   <= '0;
            APB_PWDATA  <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            access_cnt  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments only; later lines in this block
            // override the pulse default below without ordering hazards.
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state       <= SETUP;
                        req_ready   <= 1'b0;
                        APB_PSEL    <= 1'b1;
                        APB_PENABLE <= 1'b0;
                        APB_PWRITE  <= req_write;
                        APB_PADDR   <= req_addr;
                        APB_PWDATA  <= req_wdata;
                        // reads never enable byte lanes
                        APB_PSTRB   <= req_write ? req_strb : '0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    APB_PENABLE <= 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
                    access_cnt  <= '0;
`endif
                end
                ACCESS: begin
                    if (APB_PREADY) begin
                        state       <= IDLE;
                        req_ready   <= 1'b1;
                        APB_PSEL    <= 1'b0;
                        APB_PENABLE <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= APB_PSLEVRR;
                        rsp_rdata   <= APB_PWRITE ? '0 : APB_PRDATA;
`ifdef APB_BRIDGE_TIMEOUT_EN
                    end else if (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // slave stalled for the whole budget: abort with error
                        state       <= IDLE;
                        req_ready   <= 1'b1;
                        APB_PSEL    <= 1'b0;
                        APB_PENABLE <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        access_cnt  <= access_cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: self-checking bench for apb_master_bridge.
// A behavioural APB slave (memory with programmable wait states and error)
// answers the bridge; a reference memory model predicts every response.
// Honours APB_BRIDGE_TIMEOUT_EN for the timeout / long-wait scenario.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = DW / 8;

    logic          APB_CLK;
    logic          APB_RESET_n;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          APB_PSEL, APB_PENABLE, APB_PWRITE;
    logic [AW-1:0] APB_PADDR;
    logic [SW-1:0] APB_PSTRB;
    logic [DW-1:0] APB_PWDATA, APB_PRDATA;
    logic          APB_PREADY, APB_PSLEVRR;

    apb_master_bridge #(.PDATA_SIZE(DW), .PADDR_SIZE(AW), .TIMEOUT_CYCLES(16)) dut (
        .APB_CLK     (APB_CLK),
        .APB_RESET_n (APB_RESET_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .APB_PSEL    (APB_PSEL),
        .APB_PENABLE (APB_PENABLE),
        .APB_PWRITE  (APB_PWRITE),
        .APB_PADDR   (APB_PADDR),
        .APB_PSTRB   (APB_PSTRB),
        .APB_PWDATA  (APB_PWDATA),
        .APB_PRDATA  (APB_PRDATA),
        .APB_PREADY  (APB_PREADY),
        .APB_PSLEVRR (APB_PSLEVRR)
    );

    initial begin
        APB_CLK = 1'b0;
        forever #5 APB_CLK = ~APB_CLK;
    end

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        int            waits;
        logic          serr;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] ref_mem [16];   // reference model of slave contents
    logic [DW-1:0] slv_mem [16];   // storage inside the behavioural slave
    int            slv_wait = 0;
    logic          slv_err  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a read returns stored data, a write merges enabled bytes
    task automatic model_xfer(input vec_t v, output logic [DW-1:0] r);
        r = '0;
        if (v.w) begin
            for (int b = 0; b < SW; b++)
                if (v.s[b]) ref_mem[v.a][8*b +: 8] = v.d[8*b +: 8];
        end else begin
            r = ref_mem[v.a];
        end
    endtask

    // Behavioural APB slave, driven on the falling edge
    initial begin
        logic [40:0] snap;
        int          acc;
        APB_PREADY  = 1'b0;
        APB_PSLEVRR = 1'b0;
        APB_PRDATA  = '0;
        snap        = '0;
        acc         = 0;
        forever begin
            @(negedge APB_CLK);
            if (APB_PSEL && !APB_PENABLE) begin
                snap = {APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA};
                acc  = 0;
                if (!APB_PWRITE) check("read_pstrb_zero", 64'(APB_PSTRB), 64'(0));
            end
            if (APB_PSEL && APB_PENABLE) begin
                check("access_hold", 64'({APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA}), 64'(snap));
                if (acc >= slv_wait) begin
                    APB_PREADY  = 1'b1;
                    APB_PSLEVRR = slv_err;
                    if (APB_PWRITE) begin
                        APB_PRDATA = $urandom();
                        for (int b = 0; b < SW; b++)
                            if (APB_PSTRB[b]) slv_mem[APB_PADDR][8*b +: 8] = APB_PWDATA[8*b +: 8];
                    end else begin
                        APB_PRDATA = slv_mem[APB_PADDR];
                    end
                end else begin
                    APB_PREADY  = 1'b0;
                    APB_PSLEVRR = 1'($urandom());
                    APB_PRDATA  = $urandom();
                end
                acc++;
            end else begin
                // noise outside ACCESS must be ignored by the bridge
                APB_PREADY  = 1'($urandom());
                APB_PSLEVRR = 1'($urandom());
                APB_PRDATA  = $urandom();
            end
        end
    end

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 30) begin
            @(negedge APB_CLK);
            guard++;
        end
        check("req_ready_seen", 64'(req_ready), 64'(1));
    endtask

    // One transfer: returns response data, error and cycles from accept to rsp_valid
    task automatic do_xfer(input vec_t v, output logic [DW-1:0] rd, output logic er, output int lat);
        slv_wait  = v.waits;
        slv_err   = v.serr;
        req_valid = 1'b1;
        req_write = v.w;
        req_addr  = v.a;
        req_wdata = v.d;
        req_strb  = v.s;
        wait_ready();
        @(negedge APB_CLK);
        // request side changes after acceptance must not disturb the transfer
        req_valid = 1'b0;
        req_write = 1'($urandom());
        req_addr  = 4'($urandom());
        req_wdata = $urandom();
        req_strb  = 4'($urandom());
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge APB_CLK);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge APB_CLK);
        check("rsp_single_pulse", 64'(rsp_valid), 64'(0));
        check("rsp_hold", 64'({rsp_err, rsp_rdata}), 64'({er, rd}));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [DW-1:0] rd;
        logic [DW-1:0] dummy;
        logic          er;
        int            lat;
        model_xfer(v, dummy);
        do_xfer(v, rd, er, lat);
        check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rd));
        check({tag, "_err"}, 64'(er), 64'(v.exp_err));
        check({tag, "_latency"}, 64'(lat), 64'(3 + v.waits));
    endtask

    vec_t tbl [11];

    initial begin
        vec_t          v;
        logic [DW-1:0] rd, exp_rd;
        logic          er;
        int            lat;
        logic [5:0]    psel_log, rv_log;
        logic          rv_seen;

        tbl[0]  = '{1'b1, 4'(ADDR_DIRECTION), 32'h0000_00FF, 4'hF, 0, 1'b0, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 4'(ADDR_INPUT),     32'h0,         4'hF, 4, 1'b0, 32'hA5A5_5A5A, 1'b0};
        tbl[2]  = '{1'b1, 4'(ADDR_OUTPUT),    32'h1234_5678, 4'h5, 1, 1'b1, 32'h0,         1'b1};
        tbl[3]  = '{1'b0, 4'(ADDR_OUTPUT),    32'h0,         4'hF, 0, 1'b0, 32'h0034_0078, 1'b0};
        tbl[4]  = '{1'b0, 4'(ADDR_DIRECTION), 32'h0,         4'h0, 2, 1'b0, 32'h0000_00FF, 1'b0};
        tbl[5]  = '{1'b1, 4'(ADDR_MODE),      32'hDEAD_BEEF, 4'h0, 0, 1'b0, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 4'(ADDR_MODE),      32'h0,         4'hF, 0, 1'b0, 32'h0,         1'b0};
        tbl[7]  = '{1'b1, 4'(ADDR_MODE),      32'hCAFE_F00D, 4'hA, 3, 1'b0, 32'h0,         1'b0};
        tbl[8]  = '{1'b0, 4'(ADDR_MODE),      32'h0,         4'hF, 0, 1'b1, 32'hCA00_F000, 1'b1};
        tbl[9]  = '{1'b1, 4'hF,               32'h0000_0001, 4'hF, 0, 1'b0, 32'h0,         1'b0};
        tbl[10] = '{1'b0, 4'hF,               32'h0,         4'hF, 1, 1'b0, 32'h0000_0001, 1'b0};

        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            slv_mem[i] = '0;
        end
        ref_mem[ADDR_INPUT] = 32'hA5A5_5A5A;
        slv_mem[ADDR_INPUT] = 32'hA5A5_5A5A;

        APB_RESET_n = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_strb    = '0;

        // reset state
        repeat (3) @(negedge APB_CLK);
        check("rst_apb_ctrl", 64'({APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PADDR, APB_PSTRB}), 64'(0));
        check("rst_pwdata", 64'(APB_PWDATA), 64'(0));
        check("rst_rsp", 64'({req_ready, rsp_valid, rsp_err}), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        APB_RESET_n = 1'b1;
        check("ready_low_before_edge", 64'(req_ready), 64'(0));
        @(negedge APB_CLK);
        check("ready_first_cycle", 64'(req_ready), 64'(1));

        // directed table
        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // back-to-back: req_valid held high across two requests
        wait_ready();
        slv_wait  = 0;
        slv_err   = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'h4;
        req_wdata = 32'h1122_3344;
        req_strb  = 4'hF;
        v = '{1'b1, 4'h4, 32'h1122_3344, 4'hF, 0, 1'b0, 32'h0, 1'b0};
        model_xfer(v, exp_rd);
        @(negedge APB_CLK);
        req_write = 1'b0;
        req_strb  = 4'hF;
        v = '{1'b0, 4'h4, 32'h0, 4'hF, 0, 1'b0, 32'h0, 1'b0};
        model_xfer(v, exp_rd);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge APB_CLK);
            psel_log[i] = APB_PSEL;
            rv_log[i]   = rsp_valid;
            if (i == 2) check("b2b_ready_with_rsp", 64'(req_ready), 64'(1));
            if (i == 3) begin
                check("b2b_second_setup", 64'({APB_PENABLE, APB_PWRITE, APB_PADDR}), 64'({1'b0, 1'b0, 4'h4}));
                req_valid = 1'b0;
            end
            if (i == 5) check("b2b_read_data", 64'(rsp_rdata), 64'(exp_rd));
        end
        check("b2b_psel_pattern", 64'(psel_log), 64'(6'b011011));
        check("b2b_rsp_pattern", 64'(rv_log), 64'(6'b100100));

        // reset asserted in the middle of an ACCESS phase
        @(negedge APB_CLK);
        wait_ready();
        slv_wait  = 8;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'(ADDR_INPUT);
        @(negedge APB_CLK);
        req_valid = 1'b0;
        repeat (2) @(negedge APB_CLK);
        check("pre_rst_in_access", 64'({APB_PSEL, APB_PENABLE}), 64'(2'b11));
        #2 APB_RESET_n = 1'b0;
        #1;
        check("async_rst_apb_ctrl", 64'({APB_PSEL, APB_PENABLE, APB_PWRITE, APB_PADDR, APB_PSTRB}), 64'(0));
        check("async_rst_pwdata", 64'(APB_PWDATA), 64'(0));
        check("async_rst_rsp", 64'({req_ready, rsp_valid, rsp_err}), 64'(0));
        check("async_rst_rdata", 64'(rsp_rdata), 64'(0));
        @(negedge APB_CLK);
        APB_RESET_n = 1'b1;
        @(negedge APB_CLK);
        check("post_rst_ready", 64'(req_ready), 64'(1));
        rv_seen = rsp_valid;
        repeat (11) begin
            @(negedge APB_CLK);
            rv_seen = rv_seen | rsp_valid;
        end
        check("no_rsp_after_rst", 64'(rv_seen), 64'(0));
        v = '{1'b0, 4'(ADDR_INPUT), 32'h0, 4'hF, 0, 1'b0, ref_mem[ADDR_INPUT], 1'b0};
        run_vec("after_rst", v);

`ifdef APB_BRIDGE_TIMEOUT_EN
        // slave never ready: abort after 16 ACCESS cycles
        v = '{1'b0, 4'(ADDR_INPUT), 32'h0, 4'hF, 1000, 1'b0, 32'h0, 1'b0};
        do_xfer(v, rd, er, lat);
        check("timeout_latency", 64'(lat), 64'(18));
        check("timeout_err", 64'(er), 64'(1));
        check("timeout_rdata", 64'(rd), 64'(0));
        // ready on exactly the 16th ACCESS cycle still completes normally
        v = '{1'b0, 4'(ADDR_INPUT), 32'h0, 4'hF, 15, 1'b0, ref_mem[ADDR_INPUT], 1'b0};
        run_vec("timeout_edge", v);
`else
        // without the timeout build, long wait states are simply tolerated
        v = '{1'b0, 4'(ADDR_INPUT), 32'h0, 4'hF, 20, 1'b0, ref_mem[ADDR_INPUT], 1'b0};
        run_vec("long_wait", v);
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            v.w     = 1'($urandom());
            v.a     = 4'($urandom());
            v.d     = $urandom();
            v.s     = 4'($urandom());
            v.waits = $urandom_range(0, 5);
            v.serr  = 1'($urandom());
            model_xfer(v, exp_rd);
            do_xfer(v, rd, er, lat);
            check($sformatf("rnd%0d_rdata", i), 64'(rd), 64'(exp_rd));
            check($sformatf("rnd%0d_err", i), 64'(er), 64'(v.serr));
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(3 + v.waits));
            repeat ($urandom_range(0, 2)) @(negedge APB_CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
